// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready on both sides,
// a zero flag and a saturating result counter. Define LOGIC_UNIT_PARITY_EN to add out_parity.
module logic_unit_pipe #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [2:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_y,
  output logic                 out_zero,
`ifdef LOGIC_UNIT_PARITY_EN
  output logic                 out_parity,
`endif
  output logic [CNT_WIDTH-1:0] op_count
);

  function automatic logic [WIDTH-1:0] logic_fn(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = a ^ b;
      3'b011:  r = ~a;
      3'b100:  r = ~(a & b);
      3'b101:  r = ~(a | b);
      3'b110:  r = ~(a ^ b);
      default: r = b;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  logic [WIDTH-1:0] a_p1, b_p1;
  logic [2:0]       op_p1;
  logic             vld_p1;
  logic [WIDTH-1:0] y_p2;
  logic             zero_p2;
  logic             vld_p2;
  logic             en_p1, en_p2;
  logic [WIDTH-1:0] y_nxt;

  assign en_p2    = !vld_p2 || out_ready;
  assign en_p1    = !vld_p1 || en_p2;
  assign in_ready = en_p1;
  assign y_nxt    = logic_fn(op_p1, a_p1, b_p1);

  // Stage 1: operand capture; data only loads on a real transfer so idle X never enters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      op_p1  <= '0;
    end else if (en_p1) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        a_p1  <= in_a;
        b_p1  <= in_b;
        op_p1 <= in_op;
      end
    end
  end

  // Stage 2: function result; y holds its last value while no valid result arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      y_p2    <= '0;
      zero_p2 <= 1'b1;
    end else if (en_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        y_p2    <= y_nxt;
        zero_p2 <= (y_nxt == '0);
      end
    end
  end

`ifdef LOGIC_UNIT_PARITY_EN
  logic par_p2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      par_p2 <= 1'b0;
    else if (en_p2 && vld_p1)
      par_p2 <= ^y_nxt;
  end
  assign out_parity = par_p2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      op_count <= '0;
    else if (vld_p2 && out_ready)
      op_count <= sat_inc(op_count);
  end

  assign out_valid = vld_p2;
  assign out_y     = y_p2;
  assign out_zero  = zero_p2;

endmodule
